// File: rtl/conv3x3_mac_pipe.sv
// conv3x3_mac_pipe: 4-stage signed KxK MAC with serial kernel load and rounding requantisation.
// Define CONV_RELU_EN to force negative saturated results to zero.
module conv3x3_mac_pipe #(
    parameter int DATA_W = 8,
    parameter int K_DIM  = 3,
    parameter int W_W    = 8,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_w_we,
    input  logic signed [W_W-1:0]         i_w_data,
    input  logic signed [ACC_W-1:0]       i_bias,
    output logic                          o_w_ready,
    input  logic                          i_valid,
    input  logic [K_DIM*K_DIM*DATA_W-1:0] i_win_flat,
    output logic signed [DATA_W-1:0]      o_data,
    output logic                          o_valid
);

    localparam int K_SZ  = K_DIM * K_DIM;
    localparam int P_W   = DATA_W + W_W;
    localparam int RS_W  = P_W + $clog2(K_DIM) + 1;
    localparam int IDX_W = (K_SZ > 1) ? $clog2(K_SZ) : 1;
    localparam int R_W   = ACC_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K_SZ - 1);
    localparam logic signed [R_W-1:0] RND =
        (SHIFT > 0) ? (R_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [R_W-1:0] MAXV = R_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [R_W-1:0] MINV = R_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [0:0] {
        LOAD,
        RUN
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         w_idx;
    logic signed [W_W-1:0]    weight [K_SZ];
    logic signed [ACC_W-1:0]  bias;

    logic                     accept;
    logic                     s1_v;
    logic signed [P_W-1:0]    s1_p [K_SZ];
    logic                     s2_v;
    logic signed [RS_W-1:0]   s2_rs [K_DIM];
    logic                     s3_v;
    logic signed [ACC_W-1:0]  s3_acc;

    logic signed [RS_W-1:0]   rs_d [K_DIM];
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [R_W-1:0]    rnd;
    logic signed [R_W-1:0]    shr;
    logic signed [DATA_W-1:0] sat;

    assign accept = i_valid && (state == RUN);

    // A write while running restarts the load at index 0; untouched
    // weights keep their previous values until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            w_idx     <= '0;
            o_w_ready <= 1'b0;
            bias      <= '0;
            for (int g = 0; g < K_SZ; g++) begin
                weight[g] <= '0;
            end
        end else if (i_w_we) begin
            if (state == RUN) begin
                weight[0] <= i_w_data;
                w_idx     <= IDX_W'(1);
                state     <= LOAD;
                o_w_ready <= 1'b0;
            end else begin
                weight[w_idx] <= i_w_data;
                if (w_idx == LAST_IDX) begin
                    bias      <= i_bias;
                    w_idx     <= '0;
                    state     <= RUN;
                    o_w_ready <= 1'b1;
                end else begin
                    w_idx <= w_idx + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < K_DIM; r++) begin
            rs_d[r] = '0;
            for (int c = 0; c < K_DIM; c++) begin
                rs_d[r] = rs_d[r] + RS_W'(s1_p[r*K_DIM+c]);
            end
        end
    end

    always_comb begin
        acc_d = bias;
        for (int r = 0; r < K_DIM; r++) begin
            acc_d = acc_d + ACC_W'(s2_rs[r]);
        end
    end

    // One extra bit keeps the rounding add from wrapping near full scale.
    always_comb begin
        rnd = R_W'(s3_acc) + RND;
        shr = rnd >>> SHIFT;
        if (shr > MAXV) begin
            sat = MAXV[DATA_W-1:0];
        end else if (shr < MINV) begin
            sat = MINV[DATA_W-1:0];
        end else begin
            sat = shr[DATA_W-1:0];
        end
`ifdef CONV_RELU_EN
        if (sat[DATA_W-1]) begin
            sat = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            s3_acc  <= '0;
            for (int g = 0; g < K_SZ; g++) begin
                s1_p[g] <= '0;
            end
            for (int r = 0; r < K_DIM; r++) begin
                s2_rs[r] <= '0;
            end
        end else begin
            s1_v <= accept;
            for (int g = 0; g < K_SZ; g++) begin
                s1_p[g] <= P_W'($signed(i_win_flat[g*DATA_W +: DATA_W]))
                         * P_W'(weight[g]);
            end
            s2_v <= s1_v;
            for (int r = 0; r < K_DIM; r++) begin
                s2_rs[r] <= rs_d[r];
            end
            s3_v    <= s2_v;
            s3_acc  <= acc_d;
            o_valid <= s3_v;
            if (s3_v) begin
                o_data <= sat;
            end
        end
    end

endmodule
